// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: RAW (Tuse/Tnew) and mult/div busy stalls, plus the mult/div busy counter.
// Optional stall statistics counters are enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs,
  input  logic [1:0] tuse_rt,
  input  logic [4:0] A3_E,
  input  logic [1:0] tnew_E,
  input  logic [4:0] A3_M,
  input  logic [1:0] tnew_M,
  input  logic       md_use_D,
  input  logic       md_start_E,
  input  logic       md_is_div_E,
  output logic       stall,
  output logic       en_pc,
  output logic       en_D,
  output logic       clr_E,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  // state   | meaning
  // MD_IDLE | busy count is zero, unit free
  // MD_BUSY | busy count non-zero, mult/div result pending
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_done_q, md_done_d;
  md_state_e        md_state;

  logic stall_rs, stall_rt, stall_md;

  always_comb begin
    stall_rs = (rs_D != 5'd0) &&
               (((rs_D == A3_E) && (tuse_rs < tnew_E)) ||
                ((rs_D == A3_M) && (tuse_rs < tnew_M)));
    stall_rt = (rt_D != 5'd0) &&
               (((rt_D == A3_E) && (tuse_rt < tnew_E)) ||
                ((rt_D == A3_M) && (tuse_rt < tnew_M)));
    stall_md = md_use_D && (md_busy || md_start_E);
  end

  assign stall   = stall_rs | stall_rt | stall_md;
  assign en_pc   = ~stall;
  assign en_D    = ~stall;
  assign clr_E   = stall;

  assign md_state = (cnt_q != '0) ? MD_BUSY : MD_IDLE;
  assign md_busy  = (md_state == MD_BUSY);
  assign md_done  = md_done_q;

  // A start in E always loads, even while the D stage is stalled; newest start wins.
  always_comb begin
    cnt_d     = cnt_q;
    md_done_d = 1'b0;
    if (md_start_E) begin
      cnt_d = md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else begin
      case (md_state)
        MD_BUSY: begin
          cnt_d     = cnt_q - 1'b1;
          md_done_d = (cnt_q == CNT_W'(1));
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      md_done_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      md_done_q <= md_done_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, md_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (stall_md && (md_stall_cnt_q != 32'hFFFF_FFFF))
        md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign md_stall_cycles = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed test-plan scenarios, then randomized cycles vs a reference model.
module tb_hazard_stall_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, A3_E, A3_M;
  logic [1:0] tuse_rs, tuse_rt, tnew_E, tnew_M;
  logic       md_use_D, md_start_E, md_is_div_E;
  logic       stall, en_pc, en_D, clr_E, md_busy, md_done;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: mult/div tracked as "last start cycle + duration" windows.
  int cyc = 0;
  int last_start = 0;
  int last_len = 0;
  bit start_valid = 0;
  longint exp_sc = 0, exp_msc = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .A3_E(A3_E), .tnew_E(tnew_E),
    .A3_M(A3_M), .tnew_M(tnew_M), .md_use_D(md_use_D), .md_start_E(md_start_E),
    .md_is_div_E(md_is_div_E), .stall(stall), .en_pc(en_pc), .en_D(en_D),
    .clr_E(clr_E), .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles(stall_cycles), .md_stall_cycles(md_stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit raw(input logic [4:0] r, input logic [1:0] tu);
    return (r != 0) && (((r == A3_E) && (tu < tnew_E)) || ((r == A3_M) && (tu < tnew_M)));
  endfunction

  function automatic bit exp_busy();
    return start_valid && (cyc > last_start) && (cyc <= last_start + last_len);
  endfunction

  function automatic bit exp_done();
    return start_valid && (cyc == last_start + last_len + 1);
  endfunction

  task automatic idle_inputs();
    reset = 0; rs_D = 0; rt_D = 0; tuse_rs = 3; tuse_rt = 3;
    A3_E = 0; tnew_E = 0; A3_M = 0; tnew_M = 0;
    md_use_D = 0; md_start_E = 0; md_is_div_E = 0;
  endtask

  // Check this cycle against the model, clock it, advance the model.
  task automatic cycle();
    bit smd, st;
    #2;
    smd = md_use_D && (exp_busy() || md_start_E);
    st  = raw(rs_D, tuse_rs) || raw(rt_D, tuse_rt) || smd;
    chk("stall", {31'd0, stall}, {31'd0, st});
    chk("en_pc", {31'd0, en_pc}, {31'd0, !st});
    chk("en_D", {31'd0, en_D}, {31'd0, !st});
    chk("clr_E", {31'd0, clr_E}, {31'd0, st});
    chk("md_busy", {31'd0, md_busy}, {31'd0, exp_busy()});
    chk("md_done", {31'd0, md_done}, {31'd0, exp_done()});
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, exp_sc[31:0]);
    chk("md_stall_cycles", md_stall_cycles, exp_msc[31:0]);
`endif
    @(posedge clk);
    if (reset) begin
      start_valid = 0; exp_sc = 0; exp_msc = 0;
    end else begin
      if (md_start_E) begin
        start_valid = 1; last_start = cyc;
        last_len = md_is_div_E ? 10 : 5;
      end
      if (st && exp_sc != 64'hFFFF_FFFF) exp_sc++;
      if (smd && exp_msc != 64'hFFFF_FFFF) exp_msc++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    cycle();                       // reset held, state now known
    reset = 0;
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);

    // lw then dependent add
    rs_D = 8; tuse_rs = 1; A3_E = 8; tnew_E = 2;
    #2;
    chk("lw_stall", {31'd0, stall}, 32'd1);
    chk("lw_en_D", {31'd0, en_D}, 32'd0);
    chk("lw_clr_E", {31'd0, clr_E}, 32'd1);
    cycle();
    A3_M = 8; tnew_M = 1; A3_E = 0; tnew_E = 0;
    #2; chk("lw_next", {31'd0, stall}, 32'd0);
    cycle();

    // $0 guard
    idle_inputs();
    rs_D = 0; A3_E = 0; tnew_E = 2; tuse_rs = 0;
    #2; chk("zero_guard", {31'd0, stall}, 32'd0);
    cycle();

    // mult then mflo
    idle_inputs();
    md_start_E = 1; md_is_div_E = 0; md_use_D = 1;
    cycle();
    md_start_E = 0;
    for (int i = 1; i <= 5; i++) begin
      #2;
      chk("mult_stall", {31'd0, stall}, 32'd1);
      chk("mult_busy", {31'd0, md_busy}, 32'd1);
      cycle();
    end
    #2;
    chk("mult_done", {31'd0, md_done}, 32'd1);
    chk("mult_release", {31'd0, stall}, 32'd0);
    chk("mult_idle", {31'd0, md_busy}, 32'd0);
    cycle();
`ifdef HAZARD_STALL_CNT_EN
    chk("cnt_total", stall_cycles, 32'd7);
    chk("cnt_md", md_stall_cycles, 32'd6);
`endif

    // div timing
    idle_inputs();
    md_start_E = 1; md_is_div_E = 1;
    cycle();
    idle_inputs();
    for (int i = 1; i <= 10; i++) begin
      #2; chk("div_busy", {31'd0, md_busy}, 32'd1);
      cycle();
    end
    #2;
    chk("div_done", {31'd0, md_done}, 32'd1);
    chk("div_idle", {31'd0, md_busy}, 32'd0);
    cycle();
    #2; chk("div_done_once", {31'd0, md_done}, 32'd0);
    cycle();

    // reset mid-divide at cnt=6
    md_start_E = 1; md_is_div_E = 1;
    cycle();
    idle_inputs();
    for (int i = 1; i <= 4; i++) cycle();
    reset = 1;
    cycle();
    reset = 0;
    #2; chk("rstmid_busy", {31'd0, md_busy}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      #2; chk("rstmid_nodone", {31'd0, md_done}, 32'd0);
      cycle();
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 79) == 0);
      rs_D        = 5'($urandom_range(0, 3));
      rt_D        = 5'($urandom_range(0, 3));
      A3_E        = 5'($urandom_range(0, 3));
      A3_M        = 5'($urandom_range(0, 3));
      tuse_rs     = 2'($urandom_range(0, 3));
      tuse_rt     = 2'($urandom_range(0, 3));
      tnew_E      = 2'($urandom_range(0, 3));
      tnew_M      = 2'($urandom_range(0, 3));
      md_use_D    = ($urandom_range(0, 2) == 0);
      md_start_E  = ($urandom_range(0, 9) == 0);
      md_is_div_E = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
